logic_reduce_unit: RTL and testbench

Parametrised, registered multi-operand logic unit. It generalises the two-input combinational gate to WIDTH-bit operands, NUM_OPS operands per result and six selectable functions: AND, OR, XOR, NAND, NOR and XNOR. Operands stream in serially over a valid/ready handshake and are folded into an accumulator. One registered result is presented per NUM_OPS operands. The block sits between an operand source and a result consumer in the gate-library datapath.

---
 rtl/logic_reduce_unit.sv | 210 +++++++++++++++++++++
 tb/tb_logic_reduce_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_reduce_unit.sv
// ---------------------------------------------------------------------------
// logic_reduce_unit
//
// Registered multi-operand logic unit. Operands of WIDTH bits stream in one
// at a time over a valid/ready handshake and are folded into an accumulator
// with one of six bitwise functions (AND, OR, XOR, NAND, NOR, XNOR). After
// NUM_OPS operands the final value is registered onto y and held, with
// out_valid high, until the consumer takes it. A new group starts only after
// the result has been accepted.
//
// Parameters:
//   WIDTH    bit width of each operand and of the result (>= 1)
//   NUM_OPS  operands folded into one result (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   op         function select, sampled with the first operand of a group
//                000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR,
//                110/111 reserved, executed as AND
//   in_valid   operand a is valid
//   in_ready   block can accept an operand this cycle
//   a          operand
//   out_valid  result y is valid
//   out_ready  consumer accepts y this cycle
//   y          registered result
//   busy       a group is in progress (ACCUM or DONE)
//   err        (only with LOGIC_REDUCE_ERR_EN) high for the whole result
//              period of a group that was started with a reserved op code
//
// Optional build macro:
//   LOGIC_REDUCE_ERR_EN  adds the err output described above. Without it,
//                        reserved op codes silently execute as AND.
// ---------------------------------------------------------------------------
module logic_reduce_unit #(
   parameter int WIDTH   = 8,
   parameter int NUM_OPS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
`ifdef LOGIC_REDUCE_ERR_EN
   output logic             busy,
   output logic             err
`else
   output logic             busy
`endif
);

   // Counter is wide enough to hold NUM_OPS-1, and never narrower than one
   // bit so the NUM_OPS == 2 case still has a real register.
   localparam int CW = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1;
   localparam logic [CW-1:0] LAST_COUNT  = CW'(NUM_OPS - 1);
   localparam logic [CW-1:0] FIRST_COUNT = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             accept;
   logic [2:0]       op_lat;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] folded;
   logic             last_operand;

   // One step of the reduction. The inverting functions share their base
   // reduction here; the complement is applied only once, on the final value,
   // so that NAND means ~(a0 & a1 & ... ) rather than a chain of pairwise
   // NANDs. Reserved codes fall through to AND.
   function automatic logic [WIDTH-1:0] fold_step(
      input logic [2:0]       f,
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH-1:0] r;
      case (f)
         3'b001, 3'b100: r = x | b;
         3'b010, 3'b101: r = x ^ b;
         default:        r = x & b;
      endcase
      return r;
   endfunction

   // Whether the final reduction needs to be complemented (NAND, NOR, XNOR).
   function automatic logic is_inverting(input logic [2:0] f);
      return (f == 3'b011) || (f == 3'b100) || (f == 3'b101);
   endfunction

   // State register. Reset drops any partial group immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and handshake outputs. in_ready depends only on the
   // state, and accept is derived from the state directly rather than from
   // in_ready, so there is no combinational path from in_ready back into
   // this block.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) begin
               next_state = ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            accept   = in_valid;
            if (in_valid && (count == LAST_COUNT)) begin
               next_state = DONE;
            end
         end
         DONE: begin
            busy = 1'b1;
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Combine the running accumulator with the incoming operand using the op
   // latched at the start of the group; the live op input is ignored here.
   always_comb begin
      folded       = fold_step(op_lat, acc, a);
      last_operand = (count == LAST_COUNT);
   end

   // Datapath registers. The first operand of a group loads the accumulator
   // and latches op. Each later accepted operand folds in; the one that
   // completes the group also registers the (possibly complemented) result
   // and raises out_valid on the same edge, so the result is visible the
   // cycle after the last operand is presented. The counter returns to zero
   // there, ready for the next group. In DONE everything holds until the
   // consumer takes the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         count     <= '0;
         op_lat    <= 3'b000;
         y         <= '0;
         out_valid <= 1'b0;
`ifdef LOGIC_REDUCE_ERR_EN
         err       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc    <= a;
                  op_lat <= op;
                  count  <= FIRST_COUNT;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc <= folded;
                  if (last_operand) begin
                     y         <= is_inverting(op_lat) ? ~folded : folded;
                     out_valid <= 1'b1;
                     count     <= '0;
`ifdef LOGIC_REDUCE_ERR_EN
                     err       <= (op_lat[2:1] == 2'b11);
`endif
                  end else begin
                     count <= count + FIRST_COUNT;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
`ifdef LOGIC_REDUCE_ERR_EN
                  err       <= 1'b0;
`endif
               end
            end
            default: begin
               out_valid <= 1'b0;
               count     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// ---------------------------------------------------------------------------
// tb_logic_reduce_unit
//
// Bench for logic_reduce_unit with WIDTH=8, NUM_OPS=4. Groups are described
// in a table of records, driven serially, and their expected results queued
// at drive time; each result is popped from the queue when the unit presents
// it. Reset, backpressure and mid-group reset are hand-written sequences.
// Define LOGIC_REDUCE_ERR_EN to also check the err output.
// ---------------------------------------------------------------------------
module tb_logic_reduce_unit;

   localparam int WIDTH   = 8;
   localparam int NUM_OPS = 4;

   logic             clk;
   logic             rst_n;
   logic [2:0]       op;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             busy;
`ifdef LOGIC_REDUCE_ERR_EN
   logic             err;
`endif

   logic_reduce_unit #(
      .WIDTH   (WIDTH),
      .NUM_OPS (NUM_OPS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
`ifdef LOGIC_REDUCE_ERR_EN
      .busy      (busy),
      .err       (err)
`else
      .busy      (busy)
`endif
   );

   typedef struct {
      string                     name;
      logic [2:0]                opFirst;
      logic [2:0]                opLater;
      logic [NUM_OPS-1:0][7:0]   operand;
      int                        gap;
      logic [7:0]                expY;
      logic                      expErr;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] y;
      logic       err;
   } exp_t;

   vec_t vecs[$];
   exp_t expQ[$];
   int   vectorsApplied;
   int   miscompares;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t makeVec(input string name, input logic [2:0] opF,
                                    input logic [2:0] opL, input logic [7:0] o0,
                                    input logic [7:0] o1, input logic [7:0] o2,
                                    input logic [7:0] o3, input int gap,
                                    input logic [7:0] expY, input logic expErr);
      vec_t v;
      v.name       = name;
      v.opFirst    = opF;
      v.opLater    = opL;
      v.operand[0] = o0;
      v.operand[1] = o1;
      v.operand[2] = o2;
      v.operand[3] = o3;
      v.gap        = gap;
      v.expY       = expY;
      v.expErr     = expErr;
      return v;
   endfunction

   // Reference reduction for random groups: combine all operands with the
   // chosen gate, then complement the whole result for the inverting codes.
   function automatic logic [7:0] refReduce(input logic [2:0] f,
                                            input logic [NUM_OPS-1:0][7:0] ops);
      logic [7:0] r;
      r = ops[0];
      for (int k = 1; k < NUM_OPS; k++) begin
         if (f == 3'd1 || f == 3'd4)      r = r | ops[k];
         else if (f == 3'd2 || f == 3'd5) r = r ^ ops[k];
         else                             r = r & ops[k];
      end
      if (f == 3'd3 || f == 3'd4 || f == 3'd5) r = ~r;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectorsApplied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one whole group. Called at a negedge; operands are presented on
   // negedges and accepted on the following posedge. The group's expected
   // result is queued here, at drive time.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      e.name = v.name;
      e.y    = v.expY;
      e.err  = v.expErr;
      expQ.push_back(e);
      for (int i = 0; i < NUM_OPS; i++) begin
         in_valid = 1'b1;
         a        = v.operand[i];
         op       = (i == 0) ? v.opFirst : v.opLater;
         checkOutput({v.name, ":in_ready"}, 32'(in_ready), 32'd1);
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         a        = 8'($urandom);
         if (i < NUM_OPS - 1) begin
            checkOutput({v.name, ":early_valid"}, 32'(out_valid), 32'd0);
            for (int g = 0; g < v.gap; g++) begin
               @(negedge clk);
               checkOutput({v.name, ":gap_valid"}, 32'(out_valid), 32'd0);
               checkOutput({v.name, ":gap_busy"}, 32'(busy), 32'd1);
            end
         end
      end
   endtask

   // Waits (bounded) for the result, pops the scoreboard and compares.
   task automatic collectResult(output exp_t e);
      int waited;
      waited = 0;
      while (!out_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (expQ.size() == 0) begin
         e.name = "unexpected";
         e.y    = 8'h00;
         e.err  = 1'b0;
         checkOutput("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = expQ.pop_front();
      checkOutput({e.name, ":latency"}, 32'(waited), 32'd0);
      checkOutput({e.name, ":out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({e.name, ":y"}, 32'(y), 32'(e.y));
      checkOutput({e.name, ":busy"}, 32'(busy), 32'd1);
      checkOutput({e.name, ":in_ready_done"}, 32'(in_ready), 32'd0);
`ifdef LOGIC_REDUCE_ERR_EN
      checkOutput({e.name, ":err"}, 32'(err), 32'(e.err));
`endif
   endtask

   // Consumer takes the result; the unit should be back in IDLE next cycle.
   task automatic releaseResult(input string name);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({name, ":cleared_valid"}, 32'(out_valid), 32'd0);
      checkOutput({name, ":idle_busy"}, 32'(busy), 32'd0);
      checkOutput({name, ":idle_ready"}, 32'(in_ready), 32'd1);
`ifdef LOGIC_REDUCE_ERR_EN
      checkOutput({name, ":err_cleared"}, 32'(err), 32'd0);
`endif
   endtask

   initial begin
      exp_t got;
      vec_t rv;
      vectorsApplied = 0;
      miscompares    = 0;
      rst_n     = 1'b0;
      op        = 3'b000;
      in_valid  = 1'b0;
      a         = 8'h00;
      out_ready = 1'b0;

      vecs.push_back(makeVec("nand",      3'd3, 3'd3, 8'hFF, 8'hF0, 8'h3C, 8'hFF, 0, 8'hCF, 1'b0));
      vecs.push_back(makeVec("or",        3'd1, 3'd1, 8'h01, 8'h02, 8'h04, 8'h80, 0, 8'h87, 1'b0));
      vecs.push_back(makeVec("nor_opchg", 3'd4, 3'd0, 8'h01, 8'h02, 8'h04, 8'h80, 0, 8'h78, 1'b0));
      vecs.push_back(makeVec("xnor_gaps", 3'd5, 3'd5, 8'h11, 8'h22, 8'h44, 8'h88, 2, 8'h00, 1'b0));
      vecs.push_back(makeVec("and",       3'd0, 3'd0, 8'hAA, 8'hFF, 8'h0F, 8'hF0, 0, 8'h00, 1'b0));
      vecs.push_back(makeVec("xor",       3'd2, 3'd2, 8'h12, 8'h34, 8'h56, 8'h78, 1, 8'h08, 1'b0));
      vecs.push_back(makeVec("xor_b",     3'd2, 3'd1, 8'hA5, 8'h5A, 8'hFF, 8'h0F, 0, 8'h0F, 1'b0));
      vecs.push_back(makeVec("or_opchg",  3'd1, 3'd5, 8'h10, 8'h20, 8'h00, 8'h01, 0, 8'h31, 1'b0));
      vecs.push_back(makeVec("nand_ones", 3'd3, 3'd3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 8'h00, 1'b0));
      vecs.push_back(makeVec("nor_zeros", 3'd4, 3'd4, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'hFF, 1'b0));
      vecs.push_back(makeVec("rsvd110",   3'd6, 3'd6, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 0, 8'h0F, 1'b1));
      vecs.push_back(makeVec("rsvd111",   3'd7, 3'd2, 8'h3C, 8'hFF, 8'hF3, 8'hFF, 1, 8'h30, 1'b1));
      for (int r = 0; r < 8; r++) begin
         rv.name    = $sformatf("rand%0d", r);
         rv.opFirst = 3'($urandom_range(0, 7));
         rv.opLater = 3'($urandom_range(0, 7));
         for (int k = 0; k < NUM_OPS; k++) rv.operand[k] = 8'($urandom);
         rv.gap     = $urandom_range(0, 2);
         rv.expY    = refReduce(rv.opFirst, rv.operand);
         rv.expErr  = (rv.opFirst == 3'd6) || (rv.opFirst == 3'd7);
         vecs.push_back(rv);
      end

      // Reset held with the clock running.
      repeat (3) @(negedge clk);
      checkOutput("reset:y", 32'(y), 32'h00);
      checkOutput("reset:out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset:busy", 32'(busy), 32'd0);
      checkOutput("reset:in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("post_reset:busy", 32'(busy), 32'd0);
      checkOutput("post_reset:in_ready", 32'(in_ready), 32'd1);
      checkOutput("post_reset:out_valid", 32'(out_valid), 32'd0);

      // Table-driven groups.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         collectResult(got);
         releaseResult(vecs[i].name);
      end

      // Backpressure: result held for three cycles with operands offered.
      applyStimulus(makeVec("bp", 3'd1, 3'd1, 8'h01, 8'h10, 8'h00, 8'h40, 0, 8'h51, 1'b0));
      collectResult(got);
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         a        = 8'h00;
         op       = 3'd0;
         @(negedge clk);
         checkOutput("bp:y_stable", 32'(y), 32'(got.y));
         checkOutput("bp:out_valid", 32'(out_valid), 32'd1);
         checkOutput("bp:in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      releaseResult("bp");

      // Reset in the middle of a group: two zeros fed into a NAND group.
      op       = 3'd3;
      a        = 8'h00;
      in_valid = 1'b1;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checkOutput("midrst:busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst:busy_async", 32'(busy), 32'd0);
      checkOutput("midrst:ready_async", 32'(in_ready), 32'd1);
      checkOutput("midrst:valid_async", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(makeVec("after_rst", 3'd0, 3'd0, 8'hF0, 8'hFF, 8'hFF, 8'h3F, 0, 8'h30, 1'b0));
      collectResult(got);
      releaseResult("after_rst");

      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
